mul_ctrl: RTL and testbench

Execute-stage sequencer for RV32M multiplies: MUL, MULH, MULHSU, MULHU. It converts source operands to magnitude plus product sign and drives the iterative unsigned shift-add multiplier through its start/cancel/stop handshake. It stalls the pipeline until the result is ready and returns the selected 32-bit half. A one-entry product cache lets a MULH/MUL pair on identical operands complete the second instruction without re-running the multiplier.

---
 rtl/mul_ctrl_if.sv | 22 ++
 rtl/mul_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mul_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_ctrl_if.sv
// Multiplier-side handshake between the multiply sequencer and the iterative
// shift-add multiplier.
interface mul_ctrl_if;
  logic        mul_start_o;
  logic        mul_cancel_o;
  logic        mul_signed_o;
  logic [31:0] mul_op1_o;
  logic [31:0] mul_op2_o;
  logic        mul_stop_i;
  logic [31:0] mul_res_l_i;
  logic [31:0] mul_res_h_i;

  modport master (
    output mul_start_o, mul_cancel_o, mul_signed_o, mul_op1_o, mul_op2_o,
    input  mul_stop_i, mul_res_l_i, mul_res_h_i
  );

  modport slave (
    input  mul_start_o, mul_cancel_o, mul_signed_o, mul_op1_o, mul_op2_o,
    output mul_stop_i, mul_res_l_i, mul_res_h_i
  );
endinterface

// File: rtl/mul_ctrl.sv
// RV32M multiply sequencer: operand magnitude/sign conversion, multiplier
// handshake, pipeline stall and a one-entry product cache.
module mul_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mul_req_i,
  input  logic [1:0]  mul_op_i,
  input  logic [31:0] mul_rs1_i,
  input  logic [31:0] mul_rs2_i,
  input  logic [4:0]  mul_rd_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_rd_o,
  output logic [1:0]  dbg_state,
  mul_ctrl_if.master  mif
);
  localparam int unsigned REG_BUS_WIDTH = 32;
  typedef logic [REG_BUS_WIDTH-1:0] REG_BUS;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Handshake: mul_start_o is a one-cycle pulse; operands and sign are held
  // in registers until mul_stop_i (product valid) or mul_cancel_o (abort,
  // which the multiplier prioritises over a same-cycle start).
  REG_BUS      op1_q, op2_q;
  logic        sgn_q;
  logic [1:0]  op_q;
  logic [4:0]  rd_q;
  logic [63:0] res_q;

  REG_BUS      key_rs1_q, key_rs2_q;
  logic        key_s1_q, key_s2_q;

  logic        c_valid_q;
  REG_BUS      c_rs1_q, c_rs2_q;
  logic        c_s1_q, c_s2_q;
  logic [63:0] c_prod_q;

  logic        s1, s2, neg1, neg2, hit;
  logic        take_hit, take_miss, capture;
  logic        start, cancel, wb_valid;
  logic [63:0] product;

  assign s1   = (mul_op_i != OP_MULHU);
  assign s2   = ~mul_op_i[1];
  assign neg1 = s1 & mul_rs1_i[31];
  assign neg2 = s2 & mul_rs2_i[31];
  assign product = {mif.mul_res_h_i, mif.mul_res_l_i};

  // The low half is sign-independent, so MUL may reuse any product of the same operands.
  assign hit = c_valid_q
             & (mul_rs1_i == c_rs1_q)
             & (mul_rs2_i == c_rs2_q)
             & ((mul_op_i == OP_MUL) | ((c_s1_q == s1) & (c_s2_q == s2)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    take_hit  = 1'b0;
    take_miss = 1'b0;
    capture   = 1'b0;
    start     = 1'b0;
    cancel    = 1'b0;
    wb_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mul_req_i && !flush_i) begin
          if (hit) begin
            take_hit = 1'b1;
            state_d  = DONE;
          end else begin
            take_miss = 1'b1;
            state_d   = START;
          end
        end
      end
      START: begin
        start = 1'b1;
        if (flush_i) begin
          cancel  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (flush_i) begin
          cancel  = 1'b1;
          state_d = IDLE;
        end else if (mif.mul_stop_i) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        wb_valid = !flush_i;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_q     <= '0;
      op2_q     <= '0;
      sgn_q     <= 1'b0;
      op_q      <= 2'b00;
      rd_q      <= 5'd0;
      res_q     <= 64'd0;
      key_rs1_q <= '0;
      key_rs2_q <= '0;
      key_s1_q  <= 1'b0;
      key_s2_q  <= 1'b0;
      c_valid_q <= 1'b0;
      c_rs1_q   <= '0;
      c_rs2_q   <= '0;
      c_s1_q    <= 1'b0;
      c_s2_q    <= 1'b0;
      c_prod_q  <= 64'd0;
    end else begin
      if (take_miss) begin
        op1_q     <= neg1 ? -mul_rs1_i : mul_rs1_i;
        op2_q     <= neg2 ? -mul_rs2_i : mul_rs2_i;
        sgn_q     <= neg1 ^ neg2;
        key_rs1_q <= mul_rs1_i;
        key_rs2_q <= mul_rs2_i;
        key_s1_q  <= s1;
        key_s2_q  <= s2;
      end
      if (take_miss || take_hit) begin
        op_q <= mul_op_i;
        rd_q <= mul_rd_i;
      end
      if (take_hit) res_q <= c_prod_q;
      if (capture) begin
        res_q     <= product;
        c_valid_q <= 1'b1;
        c_rs1_q   <= key_rs1_q;
        c_rs2_q   <= key_rs2_q;
        c_s1_q    <= key_s1_q;
        c_s2_q    <= key_s2_q;
        c_prod_q  <= product;
      end
    end
  end

  assign mif.mul_start_o  = start;
  assign mif.mul_cancel_o = cancel;
  assign mif.mul_signed_o = sgn_q;
  assign mif.mul_op1_o    = op1_q;
  assign mif.mul_op2_o    = op2_q;

  assign wb_valid_o = wb_valid;
  assign wb_data_o  = (op_q == OP_MUL) ? res_q[31:0] : res_q[63:32];
  assign wb_rd_o    = rd_q;
  assign stall_o    = mul_req_i & ~wb_valid;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: behavioural multiplier, arithmetic reference model with
// a one-entry cache predictor, and a write-back scoreboard.
module tb_mul_ctrl;
  logic        clk;
  logic        rst_n;
  logic        mul_req_i;
  logic [1:0]  mul_op_i;
  logic [31:0] mul_rs1_i;
  logic [31:0] mul_rs2_i;
  logic [4:0]  mul_rd_i;
  logic        flush_i;
  logic        stall_o;
  logic        wb_valid_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic [1:0]  dbg_state;

  mul_ctrl_if mif();

  mul_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mul_req_i  (mul_req_i),
    .mul_op_i   (mul_op_i),
    .mul_rs1_i  (mul_rs1_i),
    .mul_rs2_i  (mul_rs2_i),
    .mul_rd_i   (mul_rd_i),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .wb_valid_o (wb_valid_o),
    .wb_data_o  (wb_data_o),
    .wb_rd_o    (wb_rd_o),
    .dbg_state  (dbg_state),
    .mif        (mif)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural multiplier ----------------
  logic        m_busy;
  int          m_cnt;
  logic [63:0] m_prod;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (mif.mul_cancel_o) begin
      m_busy <= 1'b0;
    end else if (mif.mul_start_o) begin
      m_busy <= 1'b1;
      m_cnt  <= (mif.mul_op1_o == 0 || mif.mul_op2_o == 0) ? 1 : 33;
    end else if (m_busy) begin
      if (m_cnt == 1) m_busy <= 1'b0;
      else            m_cnt  <= m_cnt - 1;
    end
  end

  always_comb begin
    m_prod = {32'd0, mif.mul_op1_o} * {32'd0, mif.mul_op2_o};
    if (mif.mul_signed_o) m_prod = -m_prod;
  end

  assign mif.mul_stop_i  = m_busy && (m_cnt == 1);
  assign mif.mul_res_l_i = mif.mul_stop_i ? m_prod[31:0]  : 32'd0;
  assign mif.mul_res_h_i = mif.mul_stop_i ? m_prod[63:32] : 32'd0;

  // ---------------- reference model ----------------
  logic        c_valid = 1'b0;
  logic [31:0] c_a, c_b;
  logic        c_s1, c_s2;

  function automatic logic sgn1(input logic [1:0] op);
    return (op == 2'b11) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic sgn2(input logic [1:0] op);
    return (op == 2'b00 || op == 2'b01) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x, y, p;
    x = sgn1(op) ? {{32{a[31]}}, a} : {32'd0, a};
    y = sgn2(op) ? {{32{b[31]}}, b} : {32'd0, b};
    p = x * y;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] ref_mag(input logic s, input logic [31:0] v);
    return (s && v[31]) ? (32'd0 - v) : v;
  endfunction

  function automatic logic ref_hit(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!c_valid || a != c_a || b != c_b) return 1'b0;
    if (op == 2'b00) return 1'b1;
    return (c_s1 == sgn1(op)) && (c_s2 == sgn2(op));
  endfunction

  task automatic cache_store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    c_valid = 1'b1;
    c_a  = a;
    c_b  = b;
    c_s1 = sgn1(op);
    c_s2 = sgn2(op);
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [36:0] exp_q[$];
  int          start_cnt = 0;
  int          cancel_cnt = 0;
  logic [31:0] snap_op1, snap_op2;
  logic        snap_sgn;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mif.mul_start_o) begin
        start_cnt++;
        snap_op1 = mif.mul_op1_o;
        snap_op2 = mif.mul_op2_o;
        snap_sgn = mif.mul_signed_o;
      end
      if (mif.mul_cancel_o) cancel_cnt++;
      if (mif.mul_stop_i && !mif.mul_cancel_o)
        check_eq("op_stable", {mif.mul_signed_o, mif.mul_op1_o, mif.mul_op2_o},
                 {snap_sgn, snap_op1, snap_op2});
      if (wb_valid_o) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_wb", 1, 0);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          check_eq("wb_data", wb_data_o, e[31:0]);
          check_eq("wb_rd", wb_rd_o, e[36:32]);
        end
      end
    end
  end

  // ---------------- driver tasks (entered at posedge + 1) ----------------
  task automatic run_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_data);
    logic hit, got;
    int   lat_exp, n, starts0;
    hit     = ref_hit(op, a, b);
    lat_exp = hit ? 1 : ((a == 0 || b == 0) ? 3 : 35);
    exp_q.push_back({rd, exp_data});
    starts0   = start_cnt;
    mul_req_i = 1'b1;
    mul_op_i  = op;
    mul_rs1_i = a;
    mul_rs2_i = b;
    mul_rd_i  = rd;
    n   = 0;
    got = 1'b0;
    @(negedge clk);
    check_eq("stall_hold", stall_o, 1);
    while (!got && n < 100) begin
      if (wb_valid_o) got = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check_eq("wb_seen", got, 1);
    check_eq("latency", n, lat_exp);
    if (got) check_eq("stall_release", stall_o, 0);
    @(posedge clk); #1;
    mul_req_i = 1'b0;
    check_eq("start_pulses", start_cnt - starts0, hit ? 0 : 1);
    if (!hit) begin
      check_eq("op1_mag", snap_op1, ref_mag(sgn1(op), a));
      check_eq("op2_mag", snap_op2, ref_mag(sgn2(op), b));
      check_eq("signed", snap_sgn, (sgn1(op) & a[31]) ^ (sgn2(op) & b[31]));
      cache_store(op, a, b);
    end
  endtask

  task automatic wait_start(output logic seen);
    int n;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      if (mif.mul_start_o) seen = 1'b1;
      n++;
    end
    check_eq("start_seen", seen, 1);
  endtask

  // Flush k cycles after the START cycle: k<34 lands in START/WAIT, k=33 on the stop, k=34 in DONE.
  task automatic run_flush(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int k);
    logic seen;
    int   cancels0;
    mul_req_i = 1'b1;
    mul_op_i  = op;
    mul_rs1_i = a;
    mul_rs2_i = b;
    mul_rd_i  = 5'd9;
    cancels0  = cancel_cnt;
    wait_start(seen);
    repeat (k) @(posedge clk);
    #1 flush_i = 1'b1;
    @(negedge clk);
    check_eq("cancel_now", mif.mul_cancel_o, (k < 34) ? 1 : 0);
    check_eq("wb_suppressed", wb_valid_o, 0);
    @(posedge clk); #1;
    flush_i   = 1'b0;
    mul_req_i = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_eq("cancel_count", cancel_cnt - cancels0, (k < 34) ? 1 : 0);
    check_eq("idle_after_flush", dbg_state, 0);
    if (k >= 34) cache_store(op, a, b);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_wb_valid"}, wb_valid_o, 0);
    check_eq({tag, "_wb_data"}, wb_data_o, 0);
    check_eq({tag, "_wb_rd"}, wb_rd_o, 0);
    check_eq({tag, "_stall"}, stall_o, 0);
    check_eq({tag, "_start"}, mif.mul_start_o, 0);
    check_eq({tag, "_cancel"}, mif.mul_cancel_o, 0);
    check_eq({tag, "_signed"}, mif.mul_signed_o, 0);
    check_eq({tag, "_op1"}, mif.mul_op1_o, 0);
    check_eq({tag, "_op2"}, mif.mul_op2_o, 0);
    check_eq({tag, "_state"}, dbg_state, 0);
  endtask

  task automatic reset_mid_wait(input logic [31:0] a, input logic [31:0] b);
    logic seen;
    mul_req_i = 1'b1;
    mul_op_i  = 2'b01;
    mul_rs1_i = a;
    mul_rs2_i = b;
    mul_rd_i  = 5'd3;
    wait_start(seen);
    repeat (6) @(posedge clk);
    #1;
    rst_n     = 1'b0;
    mul_req_i = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n   = 1'b1;
    c_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] specials[4];
    logic [31:0] pa, pb, a, b;
    logic [1:0]  op;
    specials[0] = 32'h8000_0000;
    specials[1] = 32'hFFFF_FFFF;
    specials[2] = 32'h0000_0001;
    specials[3] = 32'h7FFF_FFFF;

    rst_n = 1'b0;
    mul_req_i = 1'b0;
    mul_op_i  = 2'b00;
    mul_rs1_i = 32'd0;
    mul_rs2_i = 32'd0;
    mul_rd_i  = 5'd0;
    flush_i   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_req(2'b00, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB);
    run_req(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000);
    run_req(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF);
    run_req(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE);
    run_req(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000);
    run_req(2'b00, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h0000_0000);
    run_req(2'b11, 32'h0000_0000, 32'h1234_5678, 5'd7, 32'h0000_0000);

    run_flush(2'b01, 32'h0000_1234, 32'hFFFF_0001, 10);
    run_req(2'b01, 32'h0000_1234, 32'hFFFF_0001, 5'd8, ref_mul(2'b01, 32'h0000_1234, 32'hFFFF_0001));
    run_flush(2'b10, 32'hDEAD_BEEF, 32'h0BAD_F00D, 33);
    run_req(2'b10, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd10, ref_mul(2'b10, 32'hDEAD_BEEF, 32'h0BAD_F00D));
    run_flush(2'b11, 32'hCAFE_0001, 32'h0000_0077, 34);
    run_req(2'b11, 32'hCAFE_0001, 32'h0000_0077, 5'd11, ref_mul(2'b11, 32'hCAFE_0001, 32'h0000_0077));

    run_req(2'b01, 32'h0000_00AB, 32'h0000_00CD, 5'd12, ref_mul(2'b01, 32'h0000_00AB, 32'h0000_00CD));
    reset_mid_wait(32'h1357_9BDF, 32'h2468_ACE0);
    run_req(2'b01, 32'h0000_00AB, 32'h0000_00CD, 5'd13, ref_mul(2'b01, 32'h0000_00AB, 32'h0000_00CD));

    pa = 32'd5;
    pb = 32'd9;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: begin a = pa; b = pb; end
        1: begin a = 32'd0; b = $urandom; end
        2: begin a = specials[$urandom_range(0, 3)]; b = specials[$urandom_range(0, 3)]; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      run_req(op, a, b, 5'($urandom_range(1, 31)), ref_mul(op, a, b));
      pa = a;
      pb = b;
    end

    repeat (5) @(posedge clk);
    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
